// File: rtl/uart_avmm_master_if.sv
// Avalon-MM bus between uart_avmm_master and the 4-bit-address UART core.
interface uart_avmm_master_if;

    logic [3:0] avm_address_o;
    logic       avm_read_o;
    logic       avm_write_o;
    logic [7:0] avm_writedata_o;
    logic [7:0] avm_readdata_i;

    modport master (
        output avm_address_o,
        output avm_read_o,
        output avm_write_o,
        output avm_writedata_o,
        input  avm_readdata_i
    );

    modport slave (
        input  avm_address_o,
        input  avm_read_o,
        input  avm_write_o,
        input  avm_writedata_o,
        output avm_readdata_i
    );

endinterface

// File: rtl/uart_avmm_master.sv
// Avalon-MM master for the UART core register map: drains a TX byte FIFO into
// the TX data register after polling status, and reads the RX data register
// when the core raises its byte-received pulse.
module uart_avmm_master #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned POST_WRITE_WAIT = 2
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [7:0]         rx_data_o,
    output logic               rx_valid_o,
    output logic               rx_overrun_o,
    uart_avmm_master_if.master avm,
    input  logic               irq_i,
    output logic               busy_o
);

    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    // Shared counter for read-latency hold and post-write guard.
    localparam int unsigned WaitW = 8;

    localparam logic [3:0] AddrTxData = 4'd0;
    localparam logic [3:0] AddrStatus = 4'd1;
    localparam logic [3:0] AddrRxData = 4'd2;

    typedef enum logic [2:0] {
        StIdle,
        StStRd,
        StStChk,
        StWr,
        StGuard,
        StRxRd,
        StRxOut
    } state_e;

    state_e           r_state, w_state_d;
    logic [WaitW-1:0] r_wait, w_wait_d;
    logic             r_st_ready, w_st_ready_d;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             r_ready_en;
    logic             w_full, w_empty, w_push, w_pop;

    logic             r_rx_pending;
    logic             w_rx_clear;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_overrun;

    logic [3:0]       r_avm_address, w_avm_address_d;
    logic             r_avm_read, w_avm_read_d;
    logic             r_avm_write, w_avm_write_d;
    logic [7:0]       r_avm_writedata, w_avm_writedata_d;

    // ------------------------------------------------------------------ FIFO
    assign w_full  = (r_count == CntW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == StWr);
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign tx_ready_o = r_ready_en && (!w_full || w_pop);
    assign w_push     = tx_valid_i && tx_ready_o;

    // FIFO pointers, occupancy and post-reset ready enable.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful below r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_i;
        end
    end

    // ------------------------------------------------------------------- FSM
    // State register plus the latency/guard counter and sampled TX ready bit.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state    <= StIdle;
            r_wait     <= '0;
            r_st_ready <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait     <= w_wait_d;
            r_st_ready <= w_st_ready_d;
        end
    end

    // Next-state: RX service beats TX, and a not-ready poll yields to RX.
    always_comb begin
        w_state_d    = r_state;
        w_wait_d     = r_wait;
        w_st_ready_d = r_st_ready;
        w_rx_clear   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_wait_d = '0;
                if (r_rx_pending) begin
                    w_state_d = StRxRd;
                end else if (!w_empty) begin
                    w_state_d = StStRd;
                end
            end
            StStRd: begin
                if (r_wait == WaitW'(READ_LATENCY)) begin
                    w_st_ready_d = avm.avm_readdata_i[0];
                    w_state_d    = StStChk;
                end else begin
                    w_wait_d = r_wait + WaitW'(1);
                end
            end
            StStChk: begin
                w_wait_d = '0;
                if (r_st_ready) begin
                    w_state_d = StWr;
                end else if (r_rx_pending) begin
                    w_state_d = StRxRd;
                end else begin
                    w_state_d = StStRd;
                end
            end
            StWr: begin
                w_wait_d  = '0;
                w_state_d = (POST_WRITE_WAIT == 0) ? StIdle : StGuard;
            end
            StGuard: begin
                if (r_wait == WaitW'(POST_WRITE_WAIT - 1)) begin
                    w_state_d = StIdle;
                end else begin
                    w_wait_d = r_wait + WaitW'(1);
                end
            end
            StRxRd: begin
                if (r_wait == WaitW'(READ_LATENCY)) begin
                    w_rx_clear = 1'b1;
                    w_state_d  = StRxOut;
                end else begin
                    w_wait_d = r_wait + WaitW'(1);
                end
            end
            StRxOut: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Bus outputs decoded from the next state so they are registered.
    always_comb begin
        w_avm_address_d   = 4'd0;
        w_avm_read_d      = 1'b0;
        w_avm_write_d     = 1'b0;
        w_avm_writedata_d = 8'd0;
        case (w_state_d)
            StStRd: begin
                w_avm_read_d    = 1'b1;
                w_avm_address_d = AddrStatus;
            end
            StRxRd: begin
                w_avm_read_d    = 1'b1;
                w_avm_address_d = AddrRxData;
            end
            StWr: begin
                w_avm_write_d     = 1'b1;
                w_avm_address_d   = AddrTxData;
                w_avm_writedata_d = r_mem[r_rd_ptr];
            end
            default: ;
        endcase
    end

    // Bus output registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_avm_address   <= 4'd0;
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_writedata <= 8'd0;
        end else begin
            r_avm_address   <= w_avm_address_d;
            r_avm_read      <= w_avm_read_d;
            r_avm_write     <= w_avm_write_d;
            r_avm_writedata <= w_avm_writedata_d;
        end
    end

    // ------------------------------------------------------------- RX path
    // A new irq wins over the clear, so an event landing as the read finishes
    // is kept rather than lost.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rx_pending <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
        end else begin
            if (irq_i) begin
                r_rx_pending <= 1'b1;
            end else if (w_rx_clear) begin
                r_rx_pending <= 1'b0;
            end
            r_rx_overrun <= irq_i && r_rx_pending && !w_rx_clear;
            if (w_rx_clear) begin
                r_rx_data <= avm.avm_readdata_i;
            end
            r_rx_valid <= (w_state_d == StRxOut);
        end
    end

    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign rx_overrun_o = r_rx_overrun;
    assign busy_o       = (r_state != StIdle) || !w_empty;

    assign avm.avm_address_o   = r_avm_address;
    assign avm.avm_read_o      = r_avm_read;
    assign avm.avm_write_o     = r_avm_write;
    assign avm.avm_writedata_o = r_avm_writedata;

endmodule

// File: tb/tb_uart_avmm_master.sv
// Directed bench for uart_avmm_master with a registered-readdata UART slave model.
module tb_uart_avmm_master;

    logic       clk_i;
    logic       arst_n_i;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       irq;
    logic       busy;

    uart_avmm_master_if avm_if ();

    uart_avmm_master #(
        .FIFO_DEPTH     (4),
        .READ_LATENCY   (1),
        .POST_WRITE_WAIT(2)
    ) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_overrun_o(rx_overrun),
        .avm         (avm_if.master),
        .irq_i       (irq),
        .busy_o      (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave / monitor state
    int         cyc = 0;
    int         ready_at_poll = 0;
    logic [7:0] rx_byte = 8'h00;
    int         n_polls = 0, n_rxrd = 0, n_wr = 0, n_rxv = 0, n_ovr = 0;
    int         n_both = 0, n_idle_bad = 0;
    logic       prev_rd1 = 1'b0, prev_rd2 = 1'b0;
    logic [7:0] wr_data [64];
    logic [3:0] wr_addr [64];
    int         wr_cyc  [64];
    int         wr_poll [64];
    logic [7:0] rxv_data = 8'h00;
    int         rxv_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Slave: readdata registered one cycle after the read address.
    always @(posedge clk_i) begin
        if (avm_if.avm_read_o) begin
            case (avm_if.avm_address_o)
                4'd1:    avm_if.avm_readdata_i <= {7'd0, (n_polls >= ready_at_poll)};
                4'd2:    avm_if.avm_readdata_i <= rx_byte;
                default: avm_if.avm_readdata_i <= 8'h00;
            endcase
        end
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        logic rd1, rd2;
        rd1 = avm_if.avm_read_o && (avm_if.avm_address_o == 4'd1);
        rd2 = avm_if.avm_read_o && (avm_if.avm_address_o == 4'd2);
        if (rd1 && !prev_rd1) n_polls = n_polls + 1;
        if (rd2 && !prev_rd2) n_rxrd = n_rxrd + 1;
        prev_rd1 = rd1;
        prev_rd2 = rd2;
        if (avm_if.avm_write_o && n_wr < 64) begin
            wr_data[n_wr] = avm_if.avm_writedata_o;
            wr_addr[n_wr] = avm_if.avm_address_o;
            wr_cyc[n_wr]  = cyc;
            wr_poll[n_wr] = n_polls;
            n_wr = n_wr + 1;
        end
        if (rx_valid) begin
            n_rxv    = n_rxv + 1;
            rxv_data = rx_data;
            rxv_cyc  = cyc;
        end
        if (rx_overrun) n_ovr = n_ovr + 1;
        if (avm_if.avm_read_o && avm_if.avm_write_o) n_both = n_both + 1;
        if (!avm_if.avm_read_o && !avm_if.avm_write_o &&
            (avm_if.avm_address_o != 4'd0 || avm_if.avm_writedata_o != 8'd0))
            n_idle_bad = n_idle_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the monitor has run for this cycle.
    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b, output int at_cyc);
        @(negedge clk_i);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk_i);
        #1;
        tx_valid = 1'b0;
        at_cyc   = cyc;
    endtask

    initial begin
        int         pc0, pc1, base_wr, base_poll, base_rxv, base_rxrd, acc;
        logic [5:0] acc_mask;

        arst_n_i = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        irq      = 1'b0;
        avm_if.avm_readdata_i = 8'h00;

        // Reset state
        #12;
        check("rst_outs", {tx_ready, rx_valid, rx_overrun, busy, avm_if.avm_read_o,
                           avm_if.avm_write_o, avm_if.avm_address_o}, 32'h0);
        check("rst_data", {avm_if.avm_writedata_o, rx_data}, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        #1;
        check("rdy_before_edge", tx_ready, 1'b0);
        @(posedge clk_i);
        #1;
        check("rdy_after_edge", tx_ready, 1'b1);

        // "Hi" with status always ready
        ready_at_poll = 0;
        push(8'h48, pc0);
        push(8'h69, pc1);
        for (int i = 0; i < 100 && n_wr < 2; i++) tick();
        check("hi_nwr", n_wr, 2);
        check("hi_d0", {wr_addr[0], wr_data[0]}, {4'd0, 8'h48});
        check("hi_d1", {wr_addr[1], wr_data[1]}, {4'd0, 8'h69});
        check("hi_latency", wr_cyc[0] - pc0, 4);
        check("hi_gap", (wr_cyc[1] - wr_cyc[0]) >= 5, 1'b1);
        check("hi_polls", {wr_poll[0], wr_poll[1]}, {32'd1, 32'd2});
        repeat (10) tick();
        check("hi_idle_busy", busy, 1'b0);

        // Five not-ready polls, ready on the sixth
        base_poll     = n_polls;
        base_wr       = n_wr;
        ready_at_poll = base_poll + 6;
        push(8'h33, pc0);
        for (int i = 0; i < 200 && n_wr == base_wr; i++) tick();
        check("poll_nwr", n_wr, base_wr + 1);
        check("poll_data", wr_data[base_wr], 8'h33);
        check("poll_at", wr_poll[base_wr], base_poll + 6);
        repeat (10) tick();

        // RX byte fetch
        base_rxv  = n_rxv;
        base_rxrd = n_rxrd;
        rx_byte   = 8'h5A;
        @(negedge clk_i);
        irq = 1'b1;
        @(negedge clk_i);
        irq = 1'b0;
        for (int i = 0; i < 30 && n_rxv == base_rxv; i++) tick();
        check("rx_data_strobe", rxv_data, 8'h5A);
        check("rx_rd", n_rxrd, base_rxrd + 1);
        repeat (5) tick();
        check("rx_single", n_rxv, base_rxv + 1);
        check("rx_hold", {rx_valid, rx_data}, {1'b0, 8'h5A});

        // irq during a not-ready poll diverts to RX first
        base_rxv      = n_rxv;
        base_wr       = n_wr;
        base_poll     = n_polls;
        ready_at_poll = base_poll + 2;
        rx_byte       = 8'hA5;
        push(8'h77, pc0);
        for (int i = 0; i < 20 && !(avm_if.avm_read_o && avm_if.avm_address_o == 4'd1); i++)
            tick();
        irq = 1'b1;
        @(posedge clk_i);
        #1;
        irq = 1'b0;
        for (int i = 0; i < 60 && n_wr == base_wr; i++) tick();
        check("div_nwr", n_wr, base_wr + 1);
        check("div_data", wr_data[base_wr], 8'h77);
        check("div_rx", {n_rxv - base_rxv, 24'd0, rxv_data}, {32'd1, 24'd0, 8'hA5});
        check("div_order", rxv_cyc < wr_cyc[base_wr], 1'b1);
        check("div_polls", n_polls, base_poll + 2);
        repeat (10) tick();

        // Two back-to-back irq cycles while in GUARD -> one overrun, one read
        ready_at_poll = 0;
        base_wr       = n_wr;
        base_rxv      = n_rxv;
        base_rxrd     = n_rxrd;
        rx_byte       = 8'hC3;
        push(8'hEE, pc0);
        for (int i = 0; i < 30 && n_wr == base_wr; i++) tick();
        irq = 1'b1;
        tick();
        tick();
        irq = 1'b0;
        repeat (20) tick();
        check("ovr_count", n_ovr, 1);
        check("ovr_rxv", n_rxv, base_rxv + 1);
        check("ovr_rxrd", n_rxrd, base_rxrd + 1);
        check("ovr_data", rx_data, 8'hC3);

        // Overfill with status never ready
        ready_at_poll = 1000000;
        base_wr       = n_wr;
        acc           = 0;
        acc_mask      = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            tx_data  = 8'h10 + 8'(i);
            tx_valid = 1'b1;
            if (tx_ready) begin
                acc++;
                acc_mask[i] = 1'b1;
            end
        end
        @(negedge clk_i);
        tx_valid = 1'b0;
        check("full_mask", acc_mask, 6'b001111);
        check("full_rdy", tx_ready, 1'b0);
        repeat (20) tick();
        check("full_nowr", n_wr, base_wr);
        ready_at_poll = 0;
        for (int i = 0; i < 200 && n_wr < base_wr + 4; i++) tick();
        repeat (30) tick();
        check("drain_nwr", n_wr, base_wr + 4);
        check("drain_data", {wr_data[base_wr], wr_data[base_wr + 1],
                             wr_data[base_wr + 2], wr_data[base_wr + 3]}, 32'h10111213);
        check("drain_busy", busy, 1'b0);

        // Reset in the middle of a status poll
        ready_at_poll = 1000000;
        base_wr       = n_wr;
        push(8'h99, pc0);
        for (int i = 0; i < 20 && !avm_if.avm_read_o; i++) tick();
        #2;
        arst_n_i = 1'b0;
        #1;
        check("mid_rst_outs", {tx_ready, rx_valid, rx_overrun, busy, avm_if.avm_read_o,
                               avm_if.avm_write_o, avm_if.avm_address_o}, 32'h0);
        check("mid_rst_data", {avm_if.avm_writedata_o, rx_data}, 32'h0);
        repeat (2) @(negedge clk_i);
        arst_n_i      = 1'b1;
        ready_at_poll = 0;
        base_poll     = n_polls;
        repeat (30) tick();
        check("post_rst_nowr", n_wr, base_wr);
        check("post_rst_nopoll", n_polls, base_poll);
        check("post_rst_busy", {busy, tx_ready}, 2'b01);

        check("bus_rd_wr_excl", n_both, 0);
        check("bus_idle_zero", n_idle_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_avmm_master.md
Name: uart_avmm_master

Overview:
- Avalon-MM master that drives the 4-bit-address UART core register map from the other side of the bus.
- Accepts TX bytes on a valid/ready stream and buffers them in a small FIFO.
- Polls the TX status register until ready, then writes the byte to the TX data register.
- On the UART RX interrupt pulse, reads the RX data register and emits the byte on an output strobe. This replaces hand-written testbench bus sequences in system integration.

Parameters:
- FIFO_DEPTH, 4, TX byte FIFO entries; power of two, ≥2.
- READ_LATENCY, 1, cycles from read address presentation to valid avm_readdata_i (slave registers readdata).
- POST_WRITE_WAIT, 2, idle cycles after a TX write before status polling resumes; covers the slave's ready-deassert delay.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous reset, active low
- tx_data_i  in  8  byte to transmit
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  FIFO not full; byte accepted when tx_valid_i && tx_ready_o
- rx_data_o  out  8  last received byte, held until next capture
- rx_valid_o  out  1  one-cycle strobe, rx_data_o updated
- rx_overrun_o  out  1  one-cycle strobe, irq_i arrived while an RX read was already pending
- avm_address_o  out  4  register address: 0=TX data, 1=status (bit0 ready), 2=RX data
- avm_read_o  out  1  read strobe
- avm_write_o  out  1  write strobe
- avm_writedata_o  out  8  write data
- avm_readdata_i  in  8  read data
- irq_i  in  1  RX byte-received pulse from UART core
- busy_o  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (async, arst_n_i low):
  - All outputs 0; FSM in IDLE; FIFO empty; rx_pending cleared.
  - Reset mid-transaction aborts immediately; no write is completed afterwards.
  - tx_ready_o rises 1 cycle after reset release.
- FIFO:
  - Circular, pointers wrap at FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle when full: allowed, count unchanged.
  - Push when full: ignored, tx_ready_o=0.
- IRQ capture:
  - irq_i high sets rx_pending on the next edge.
  - irq_i high while rx_pending is already set: rx_overrun_o pulses, rx_pending stays 1, the older byte is lost.
  - irq_i on the same cycle rx_pending clears: the new event re-sets it; no overrun.
- FSM states: IDLE, ST_RD, ST_CHK, WR, GUARD, RX_RD, RX_OUT.
- IDLE:
  - If rx_pending -> RX_RD. RX has priority over TX.
  - Else if FIFO not empty -> ST_RD.
- ST_RD:
  - avm_read_o=1, avm_address_o=1, held for READ_LATENCY+1 cycles.
  - avm_readdata_i[0] is sampled at the final edge -> ST_CHK.
- ST_CHK (one cycle, bus idle):
  - Ready=1 -> WR.
  - Ready=0 and rx_pending -> RX_RD.
  - Ready=0 otherwise -> ST_RD (repoll).
- WR:
  - Exactly one cycle: avm_write_o=1, avm_address_o=0, avm_writedata_o=FIFO head.
  - FIFO pops on this edge -> GUARD.
- GUARD: bus idle for POST_WRITE_WAIT cycles -> IDLE.
- RX_RD:
  - avm_read_o=1, avm_address_o=2, held for READ_LATENCY+1 cycles.
  - rx_data_o <= avm_readdata_i and rx_pending clears at the final edge -> RX_OUT.
- RX_OUT: rx_valid_o=1 for one cycle -> IDLE.
- Bus rules:
  - avm_read_o and avm_write_o are never both 1.
  - In idle cycles avm_address_o=0, avm_writedata_o=0.
  - All bus outputs are registered.
  - No write is ever issued without a ready=1 status read since the last write.
- Latency: FIFO byte accepted at edge N with FSM idle and slave ready -> avm_write_o at cycle N+1+(READ_LATENCY+1)+1 (N+4 at default).

Test Plan:
- Push 0x48 then 0x69 ("Hi") with status readdata=0x01 always -> exactly two writes, address 0, data 0x48 then 0x69; each write preceded by an address-1 read; writes at least POST_WRITE_WAIT+READ_LATENCY+2 cycles apart.
- Status returns 0x00 for 5 polls, then 0x01 -> 5 repolls with no write, then a single write of the queued byte.
- Pulse irq_i with slave returning 0x5A at address 2 -> address-2 read, then rx_valid_o 1-cycle pulse with rx_data_o=0x5A; rx_data_o holds afterwards.
- irq_i pulse during a status poll with ready=0 -> ST_CHK diverts to RX read; the TX byte is written after the RX byte is delivered; byte order unchanged.
- Two irq_i pulses 1 cycle apart while the FSM is in GUARD -> rx_overrun_o pulses once, then one RX read and one rx_valid_o.
- Push 6 bytes back-to-back at FIFO_DEPTH=4 with ready=0 -> tx_ready_o low after 4 accepted; set ready=1 -> the 4 accepted bytes written in order; the 2 rejected bytes are never written. Assert arst_n_i low mid-poll -> all outputs 0 and FIFO empty.
